// File: rtl/kbd_disp_port_if.sv
// ============================================================================
// Module      : kbd_disp_port_if
// Description : Keyboard-input / display-output bus between the CPU side,
//               the keyboard and display devices, and the kbd_disp_port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface kbd_disp_port_if #(
   parameter int DW = 8
);
   logic          key_strobe;
   logic [DW-1:0] key_data;
   logic [DW-1:0] inpr;
   logic          fgi;
   logic          inp_ack;
   logic          kb_ovf;
   logic [DW-1:0] outr;
   logic          out_ld;
   logic          fgo;
   logic [DW-1:0] display;
   logic          disp_valid;
   logic          disp_ready;
   logic          ien_in;
   logic          ien_out;
   logic          irq;

   modport slave (
      input  key_strobe, key_data, inp_ack, outr, out_ld, disp_ready,
             ien_in, ien_out,
      output inpr, fgi, kb_ovf, fgo, display, disp_valid, irq
   );

   modport master (
      output key_strobe, key_data, inp_ack, outr, out_ld, disp_ready,
             ien_in, ien_out,
      input  inpr, fgi, kb_ovf, fgo, display, disp_valid, irq
   );
endinterface

`default_nettype wire

// File: rtl/kbd_disp_port.sv
// ============================================================================
// Module      : kbd_disp_port
// Description : Keyboard FIFO (INPR/FGI) and display handshake (OUTR/FGO)
//               endpoint with a registered combined interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_disp_port #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  wire                    clk,
   input  wire                    rst,
   kbd_disp_port_if.slave         bus
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   logic [DW-1:0]   mem_q [DEPTH];
   logic [DW-1:0]   mem_d [DEPTH];
   logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_CW-1:0] count_q, count_d;
   logic            kb_ovf_q, kb_ovf_d;
   logic [DW-1:0]   display_q, display_d;
   logic            irq_q, irq_d;
   state_t          state_q, state_d;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_ovf_set;
   logic w_fgi;
   logic w_fgo;

   assign w_empty   = (count_q == '0);
   assign w_full    = (count_q == c_CW'(DEPTH));
   assign w_pop     = bus.inp_ack & ~w_empty;
   // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
   assign w_push    = bus.key_strobe & (~w_full | w_pop);
   assign w_ovf_set = bus.key_strobe & w_full & ~w_pop;
   assign w_fgi     = ~w_empty;
   assign w_fgo     = (state_q == ST_IDLE);

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      kb_ovf_d = kb_ovf_q;

      if (w_push) begin
         mem_d[wr_ptr_q] = bus.key_data;
         wr_ptr_d        = wr_ptr_q + c_AW'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_AW'(1);
      end

      case ({w_push, w_pop})
         2'b10:   count_d = count_q + c_CW'(1);
         2'b01:   count_d = count_q - c_CW'(1);
         default: count_d = count_q;
      endcase

      // A fresh overflow outranks the clear from an accepted pop.
      if (w_ovf_set) begin
         kb_ovf_d = 1'b1;
      end else if (w_pop) begin
         kb_ovf_d = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      display_d = display_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.out_ld) begin
               display_d = bus.outr;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus.disp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign irq_d = (bus.ien_in & w_fgi) | (bus.ien_out & w_fgo);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         kb_ovf_q  <= 1'b0;
         display_q <= '0;
         irq_q     <= 1'b0;
         state_q   <= ST_IDLE;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         kb_ovf_q  <= kb_ovf_d;
         display_q <= display_d;
         irq_q     <= irq_d;
         state_q   <= state_d;
      end
   end

   assign bus.inpr       = w_empty ? '0 : mem_q[rd_ptr_q];
   assign bus.fgi        = w_fgi;
   assign bus.kb_ovf     = kb_ovf_q;
   assign bus.fgo        = w_fgo;
   assign bus.display    = display_q;
   assign bus.disp_valid = (state_q == ST_BUSY);
   assign bus.irq        = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_kbd_disp_port.sv
// ============================================================================
// Module      : tb_kbd_disp_port
// Description : Directed self-checking bench for kbd_disp_port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kbd_disp_port;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   kbd_disp_port_if #(.DW(8)) bus ();

   kbd_disp_port #(.DEPTH(4), .DW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_key(input logic [7:0] k);
      bus.key_strobe = 1'b1;
      bus.key_data   = k;
      tick();
      bus.key_strobe = 1'b0;
   endtask

   task automatic ack();
      bus.inp_ack = 1'b1;
      tick();
      bus.inp_ack = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_q [4];
      total = 0;
      bad   = 0;
      bus.key_strobe = 1'b0;
      bus.key_data   = '0;
      bus.inp_ack    = 1'b0;
      bus.outr       = '0;
      bus.out_ld     = 1'b0;
      bus.disp_ready = 1'b0;
      bus.ien_in     = 1'b0;
      bus.ien_out    = 1'b0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      chk("rst_fgo",   bus.fgo, 1);
      chk("rst_fgi",   bus.fgi, 0);
      chk("rst_inpr",  bus.inpr, 0);
      chk("rst_ovf",   bus.kb_ovf, 0);
      chk("rst_disp",  bus.display, 0);
      chk("rst_dval",  bus.disp_valid, 0);
      chk("rst_irq",   bus.irq, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // single key, then pop
      push_key(8'h77);
      chk("k77_fgi",  bus.fgi, 1);
      chk("k77_inpr", bus.inpr, 8'h77);
      tick();
      tick();
      ack();
      chk("pop_fgi",  bus.fgi, 0);
      chk("pop_inpr", bus.inpr, 0);
      ack();
      chk("ack_empty_fgi", bus.fgi, 0);

      // overflow with five keys into a four-deep FIFO
      push_key(8'h11);
      push_key(8'h22);
      push_key(8'h33);
      push_key(8'h44);
      chk("full_ovf0", bus.kb_ovf, 0);
      push_key(8'h55);
      chk("ovf_set", bus.kb_ovf, 1);
      exp_q = '{8'h22, 8'h33, 8'h44, 8'h00};
      chk("ovf_head", bus.inpr, 8'h11);
      for (int i = 0; i < 4; i++) begin
         ack();
         chk("ovf_drain", bus.inpr, exp_q[i]);
         if (i == 0) chk("ovf_clr", bus.kb_ovf, 0);
      end
      chk("ovf_empty", bus.fgi, 0);

      // simultaneous push and pop while full
      push_key(8'h11);
      push_key(8'h22);
      push_key(8'h33);
      push_key(8'h44);
      bus.key_strobe = 1'b1;
      bus.key_data   = 8'h99;
      ack();
      bus.key_strobe = 1'b0;
      chk("sim_head", bus.inpr, 8'h22);
      chk("sim_ovf",  bus.kb_ovf, 0);
      push_key(8'hAA);
      chk("sim_still_full", bus.kb_ovf, 1);
      exp_q = '{8'h33, 8'h44, 8'h99, 8'h00};
      for (int i = 0; i < 4; i++) begin
         ack();
         chk("sim_drain", bus.inpr, exp_q[i]);
      end
      chk("sim_ovf_clr", bus.kb_ovf, 0);

      // simultaneous push and pop while empty: push only
      bus.key_strobe = 1'b1;
      bus.key_data   = 8'h5E;
      ack();
      bus.key_strobe = 1'b0;
      chk("emp_sim_fgi",  bus.fgi, 1);
      chk("emp_sim_inpr", bus.inpr, 8'h5E);
      ack();
      chk("emp_sim_pop", bus.fgi, 0);

      // display path
      bus.outr   = 8'hA5;
      bus.out_ld = 1'b1;
      tick();
      bus.out_ld = 1'b0;
      chk("out_disp", bus.display, 8'hA5);
      chk("out_dval", bus.disp_valid, 1);
      chk("out_fgo",  bus.fgo, 0);
      bus.outr   = 8'h3C;
      bus.out_ld = 1'b1;
      tick();
      bus.out_ld = 1'b0;
      chk("busy_ld_ign", bus.display, 8'hA5);
      bus.disp_ready = 1'b1;
      tick();
      bus.disp_ready = 1'b0;
      chk("done_fgo",  bus.fgo, 1);
      chk("done_dval", bus.disp_valid, 0);
      chk("done_disp", bus.display, 8'hA5);
      bus.outr   = 8'h5A;
      bus.out_ld = 1'b1;
      tick();
      bus.outr       = 8'hC3;
      bus.disp_ready = 1'b1;
      tick();
      bus.out_ld     = 1'b0;
      bus.disp_ready = 1'b0;
      chk("edge_ld_fgo",  bus.fgo, 1);
      chk("edge_ld_disp", bus.display, 8'h5A);

      // interrupt request
      bus.ien_in = 1'b1;
      push_key(8'h66);
      chk("irq_lag", bus.irq, 0);
      tick();
      chk("irq_in", bus.irq, 1);
      bus.ien_out = 1'b1;
      ack();
      tick();
      chk("irq_out", bus.irq, 1);
      bus.ien_out = 1'b0;
      tick();
      chk("irq_off", bus.irq, 0);

      // asynchronous reset mid-transfer
      push_key(8'h12);
      push_key(8'h34);
      bus.outr   = 8'hE7;
      bus.out_ld = 1'b1;
      tick();
      bus.out_ld = 1'b0;
      chk("pre_dval", bus.disp_valid, 1);
      chk("pre_irq",  bus.irq, 1);
      #2 rst = 1'b0;
      #1;
      chk("ar_fgo",  bus.fgo, 1);
      chk("ar_dval", bus.disp_valid, 0);
      chk("ar_fgi",  bus.fgi, 0);
      chk("ar_inpr", bus.inpr, 0);
      chk("ar_disp", bus.display, 0);
      chk("ar_irq",  bus.irq, 0);
      tick();
      rst = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
